// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver:
//   - parity_mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD; code 3 also means none)
//   - baud code constants and baud_div(), which turns a clock frequency and a
//     baud code into a rounded-to-nearest clocks-per-bit divisor
//   - FSM state encodings used by both directions
// ---------------------------------------------------------------------------
package uart_pkg;

    // Width of the clocks-per-bit counters; wide enough for 9600 baud from
    // clocks well above 100 MHz.
    localparam int DIV_W = 24;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Unused codes (5..7) fall back to 9600 baud.
    function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz,
                                                  input logic [2:0]  code);
        int unsigned baud;
        int unsigned div;
        case (code)
            BAUD_19200:  baud = 32'd19200;
            BAUD_38400:  baud = 32'd38400;
            BAUD_57600:  baud = 32'd57600;
            BAUD_115200: baud = 32'd115200;
            default:     baud = 32'd9600;
        endcase
        div = (clk_hz + baud / 32'd2) / baud;
        return div[DIV_W-1:0];
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_if
// Valid/ready word channel into the UART transmitter.
//   s_data  : word to send (DATA_W bits)
//   s_valid : producer has a word on s_data
//   s_ready : transmitter can take a word; transfer on s_valid && s_ready
// master = producer side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_frame_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Small synchronous FIFO placed in front of the transmitter FSM when the
// UART_TX_FIFO_EN build option is defined.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : write a word; ignored while full
//   pop/rdata  : rdata shows the oldest word; pop discards it; ignored when empty
//   full/empty : occupancy flags
//   count      : number of stored words
// DEPTH must be a power of two (pointers wrap naturally) and at least 2.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// UART transmitter: serialises one DATA_W-bit word per frame, LSB first, as
// start bit, data bits, optional parity bit and one or two stop bits. Baud
// rate, parity and stop-bit count are sampled when a word enters the FSM and
// stay fixed for that frame.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   s           : valid/ready word input (uart_tx_frame_if.slave)
//   set_baud    : 0=9600 1=19200 2=38400 3=57600 4=115200 (5..7 = 9600)
//   parity_mode : 0=none 1=even 2=odd 3=none
//   stop2       : 1 = two stop bits
//   tx          : serial line, idles high
//   busy        : frame in progress (or words pending in the FIFO)
//   tx_done     : one-cycle pulse after each frame
// Build option: define UART_TX_FIFO_EN to put a FIFO_DEPTH-word FIFO in
// front of the FSM (s_ready = !full, one extra clock of first-word latency).
// ---------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_frame_if.slave        s,
    input  logic [2:0]            set_baud,
    input  logic [1:0]            parity_mode,
    input  logic                  stop2,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);
    localparam int               IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    localparam logic [DIV_W-1:0] DIV_9600   = baud_div(CLK_HZ, BAUD_9600);
    localparam logic [DIV_W-1:0] DIV_19200  = baud_div(CLK_HZ, BAUD_19200);
    localparam logic [DIV_W-1:0] DIV_38400  = baud_div(CLK_HZ, BAUD_38400);
    localparam logic [DIV_W-1:0] DIV_57600  = baud_div(CLK_HZ, BAUD_57600);
    localparam logic [DIV_W-1:0] DIV_115200 = baud_div(CLK_HZ, BAUD_115200);

    uart_state_e       state;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_sel;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              par_en_q;
    logic              par_bit_q;
    logic              stop2_q;
    logic              stop_idx;
    logic              bit_end;
    logic              start_req;
    logic [DATA_W-1:0] start_data;

`ifdef UART_TX_FIFO_EN
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          fifo_pop;
    logic                          fifo_push;
    logic [DATA_W-1:0]             fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    assign fifo_push = s.s_valid && !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (s.s_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign s.s_ready  = !fifo_full;
    assign start_req  = !fifo_empty;
    assign start_data = fifo_rdata;
    assign busy       = (state != ST_IDLE) || !fifo_empty;
`else
    assign s.s_ready  = (state == ST_IDLE);
    assign start_req  = s.s_valid;
    assign start_data = s.s_data;
    assign busy       = (state != ST_IDLE);
`endif

    // Divisors are elaboration-time constants; only the selection is logic.
    always_comb begin
        div_sel = DIV_9600;
        case (set_baud)
            BAUD_19200:  div_sel = DIV_19200;
            BAUD_38400:  div_sel = DIV_38400;
            BAUD_57600:  div_sel = DIV_57600;
            BAUD_115200: div_sel = DIV_115200;
            default:     div_sel = DIV_9600;
        endcase
    end

    assign bit_end = (cnt == div_q - 1'b1);

    // tx is registered and always presents the bit currently being held;
    // each bit change loads the next bit's value on the same edge the state
    // and counter advance. The edge that ends the final stop bit returns to
    // IDLE and raises tx_done for the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
            cnt       <= '0;
            div_q     <= DIV_9600;
            bit_idx   <= '0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            stop_idx  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state == ST_IDLE) begin
                tx <= 1'b1;
                if (start_req) begin
                    shreg     <= start_data;
                    div_q     <= div_sel;
                    par_en_q  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
                    par_bit_q <= (parity_mode == PAR_ODD) ? ~^start_data : ^start_data;
                    stop2_q   <= stop2;
                    cnt       <= '0;
                    bit_idx   <= '0;
                    stop_idx  <= 1'b0;
                    tx        <= 1'b0;
                    state     <= ST_START;
                end
            end else if (!bit_end) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                case (state)
                    ST_START: begin
                        tx    <= shreg[0];
                        state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_idx == LAST_IDX) begin
                            if (par_en_q) begin
                                tx    <= par_bit_q;
                                state <= ST_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            tx      <= shreg[1];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (stop2_q && !stop_idx) begin
                            stop_idx <= 1'b1;
                        end else begin
                            tx      <= 1'b1;
                            tx_done <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                    default: begin
                        tx    <= 1'b1;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
// Self-checking bench for uart_tx_frame. Expected line activity comes from a
// frame model that lists the bits of a frame and the clocks per bit from the
// baud rate; every clock of every bit is compared against it.
// Honours UART_TX_FIFO_EN (adds the FIFO burst scenario and the extra clock
// of first-word latency).
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;
    localparam int CLK_HZ     = 50_000_000;
    localparam int FIFO_DEPTH = 4;
    localparam int BUDGET     = 20000;
`ifdef UART_TX_FIFO_EN
    localparam int  LAT       = 1;
    localparam bit  FIFO_MODE = 1'b1;
`else
    localparam int  LAT       = 0;
    localparam bit  FIFO_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] set_baud = 3'd4;
    logic [1:0] parity_mode = 2'd0;
    logic       stop2 = 1'b0;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int tests = 0;
    int fails = 0;

    uart_tx_frame_if #(.DATA_W(8)) bus ();

    uart_tx_frame #(
        .CLK_HZ     (CLK_HZ),
        .DATA_W     (8),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s           (bus),
        .set_baud    (set_baud),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .tx          (tx),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    // Clocks per bit: nearest integer to CLK_HZ / baud rate.
    function automatic int model_div(input logic [2:0] code);
        int baud;
        case (code)
            3'd1:    baud = 19200;
            3'd2:    baud = 38400;
            3'd3:    baud = 57600;
            3'd4:    baud = 115200;
            default: baud = 9600;
        endcase
        return (CLK_HZ + baud / 2) / baud;
    endfunction

    // Line bits of one frame in send order; returns the bit count.
    function automatic int model_bits(input logic [7:0] d, input logic [1:0] pm,
                                      input bit s2, output logic [11:0] bits);
        int n;
        int ones;
        bits = '1;
        ones = 0;
        bits[0] = 1'b0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[i];
            if (d[i]) ones++;
            n++;
        end
        if (pm == 2'd1) begin
            bits[n] = ((ones % 2) == 1);
            n++;
        end else if (pm == 2'd2) begin
            bits[n] = ((ones % 2) == 0);
            n++;
        end
        n = n + (s2 ? 2 : 1);
        return n;
    endfunction

    // Called just after a negedge; returns just after the negedge that
    // follows the accepting posedge, with s_valid still asserted.
    task automatic push_word(input logic [7:0] d, output bit ok);
        ok = 1'b0;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            if (bus.s_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL push_%h: s_ready stayed 0 for %0d clocks, required 1", d, BUDGET);
        end
    endtask

    // Waits for the start bit, checks every clock of every bit, then checks
    // the tx_done cycle. Returns just after the negedge of the tx_done cycle.
    // start_wait = negedges waited for the start bit (-1 on timeout).
    task automatic check_frame(input string name, input logic [7:0] d,
                               input logic [2:0] code, input logic [1:0] pm,
                               input bit s2, input bit busy_after,
                               input bit toggle_baud, output int start_wait);
        logic [11:0] bits;
        logic [2:0]  orig_baud;
        logic        bad_val;
        int          nbits;
        int          div;
        int          bad_cnt;
        bit          ctl_bad;
        nbits = model_bits(d, pm, s2, bits);
        div = model_div(code);
        orig_baud = set_baud;
        start_wait = 0;
        while (tx !== 1'b0 && start_wait < BUDGET) begin
            @(negedge clk);
            start_wait++;
        end
        if (tx !== 1'b0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_start: tx=%b after %0d clocks, required 0", name, tx, BUDGET);
            start_wait = -1;
            return;
        end
        ctl_bad = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            bad_cnt = 0;
            bad_val = bits[b];
            for (int c = 0; c < div; c++) begin
                if (toggle_baud && c == 0 && b == 3) set_baud = 3'd3;
                if (toggle_baud && c == 0 && b == 7) set_baud = orig_baud;
                if (tx !== bits[b]) begin
                    bad_cnt++;
                    bad_val = tx;
                end
                if (busy !== 1'b1 || tx_done !== 1'b0) ctl_bad = 1'b1;
                if (!(b == nbits - 1 && c == div - 1)) @(negedge clk);
            end
            tests++;
            if (bad_cnt != 0) begin
                fails++;
                $display("[TB] FAIL %s_bit%0d: tx=%b on %0d of %0d clocks, required %b",
                         name, b, bad_val, bad_cnt, div, bits[b]);
            end
        end
        tests++;
        if (ctl_bad) begin
            fails++;
            $display("[TB] FAIL %s_flags: busy/tx_done wrong inside frame, required busy=1 tx_done=0", name);
        end
        @(negedge clk);
        tests++;
        if (tx_done !== 1'b1 || tx !== 1'b1 || busy !== busy_after) begin
            fails++;
            $display("[TB] FAIL %s_end: tx_done=%b tx=%b busy=%b, required 1 1 %b",
                     name, tx_done, tx, busy, busy_after);
        end
`ifndef UART_TX_FIFO_EN
        tests++;
        if (bus.s_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s_ready: s_ready=%b in tx_done cycle, required 1", name, bus.s_ready);
        end
`endif
    endtask

    task automatic check_idle_after(input string name);
        @(negedge clk);
        tests++;
        if (tx_done !== 1'b0 || tx !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s_pulse: tx_done=%b tx=%b one cycle later, required 0 1", name, tx_done, tx);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (tx !== 1'b1) begin fails++; $display("[TB] FAIL rst_tx: tx=%b, required 1", tx); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_busy: busy=%b, required 0", busy); end
        tests++;
        if (tx_done !== 1'b0) begin fails++; $display("[TB] FAIL rst_done: tx_done=%b, required 0", tx_done); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL post_rst_idle: tx=%b busy=%b tx_done=%b, required 1 0 0", tx, busy, tx_done);
        end
        tests++;
        if (bus.s_ready !== 1'b1) begin fails++; $display("[TB] FAIL post_rst_ready: s_ready=%b, required 1", bus.s_ready); end
    endtask

    task automatic test_a5();
        bit ok;
        int sw;
        set_baud = 3'd4; parity_mode = 2'd0; stop2 = 1'b0;
        push_word(8'hA5, ok);
        bus.s_valid = 1'b0;
        check_frame("a5", 8'hA5, 3'd4, 2'd0, 1'b0, 1'b0, 1'b0, sw);
        tests++;
        if (sw != LAT) begin fails++; $display("[TB] FAIL a5_latency: start bit after %0d clocks, required %0d", sw, LAT); end
        check_idle_after("a5");
    endtask

    task automatic test_parity();
        bit ok;
        int sw;
        stop2 = 1'b1; set_baud = 3'd4;
        for (int m = 1; m <= 2; m++) begin
            parity_mode = 2'(m);
            push_word(8'h07, ok);
            bus.s_valid = 1'b0;
            check_frame(m == 1 ? "par_even" : "par_odd", 8'h07, 3'd4, 2'(m), 1'b1, 1'b0, 1'b0, sw);
            check_idle_after("parity");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [3];
        logic [1:0] pm;
        bit         s2;
        int         sw;
        bit         ok;
        for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
        pm = 2'($urandom_range(0, 3));
        s2 = 1'($urandom_range(0, 1));
        set_baud = 3'd4; parity_mode = pm; stop2 = s2;
        fork
            begin
                for (int i = 0; i < 3; i++) push_word(w[i], ok);
                bus.s_valid = 1'b0;
            end
            begin
                check_frame("b2b_f1", w[0], 3'd4, pm, s2, FIFO_MODE, 1'b0, sw);
                check_frame("b2b_f2", w[1], 3'd4, pm, s2, FIFO_MODE, 1'b1, sw);
                tests++;
                if (sw != 1) begin fails++; $display("[TB] FAIL b2b_gap2: %0d idle clocks, required 1", sw); end
                check_frame("b2b_f3", w[2], 3'd4, pm, s2, 1'b0, 1'b0, sw);
                tests++;
                if (sw != 1) begin fails++; $display("[TB] FAIL b2b_gap3: %0d idle clocks, required 1", sw); end
            end
        join
        check_idle_after("b2b");
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit bad;
        int sw;
        int waited;
        set_baud = 3'd4; parity_mode = 2'd0; stop2 = 1'b0;
        push_word(8'h2F, ok);
        bus.s_valid = 1'b0;
        waited = 0;
        while (tx !== 1'b0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        // Move to the middle of data bit 4 (line bit 5); 8'h2F has bit 4 = 0.
        repeat (5 * model_div(3'd4) + 199) @(negedge clk);
        tests++;
        if (tx !== 1'b0) begin fails++; $display("[TB] FAIL mid_bit4: tx=%b before reset, required 0", tx); end
        rst_n = 1'b0;
        #1;
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_rst: tx=%b busy=%b tx_done=%b, required 1 0 0", tx, busy, tx_done);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (5000) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || tx !== 1'b1) bad = 1'b1;
        end
        tests++;
        if (bad) begin fails++; $display("[TB] FAIL mid_quiet: line activity or tx_done after reset, required none"); end
        push_word(8'h3C, ok);
        bus.s_valid = 1'b0;
        check_frame("after_rst_3c", 8'h3C, 3'd4, 2'd0, 1'b0, 1'b0, 1'b0, sw);
        check_idle_after("after_rst_3c");
    endtask

    task automatic test_baud_codes();
        logic [2:0] codes [5];
        logic [7:0] d;
        bit         ok;
        int         lows;
        int         waited;
        codes = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        parity_mode = 2'd0; stop2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_baud = codes[i];
            d = 8'($urandom) | 8'h01;
            push_word(d, ok);
            bus.s_valid = 1'b0;
            waited = 0;
            while (tx !== 1'b0 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            lows = 0;
            while (tx === 1'b0 && lows < 6000) begin
                lows++;
                @(negedge clk);
            end
            tests++;
            if (lows != model_div(codes[i])) begin
                fails++;
                $display("[TB] FAIL baud_code%0d: start bit %0d clocks, required %0d", codes[i], lows, model_div(codes[i]));
            end
            pulse_reset();
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        logic [2:0] code;
        logic [1:0] pm;
        bit         s2;
        bit         ok;
        int         sw;
        repeat (2) begin
            d    = 8'($urandom);
            code = ($urandom_range(0, 1) == 1) ? 3'd3 : 3'd4;
            pm   = 2'($urandom_range(0, 3));
            s2   = 1'($urandom_range(0, 1));
            set_baud = code; parity_mode = pm; stop2 = s2;
            push_word(d, ok);
            bus.s_valid = 1'b0;
            check_frame("random", d, code, pm, s2, 1'b0, 1'b0, sw);
            check_idle_after("random");
        end
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo_burst();
        logic [7:0] w [FIFO_DEPTH + 1];
        int         accepted;
        bit         dropped;
        int         sw;
        for (int i = 0; i <= FIFO_DEPTH; i++) w[i] = 8'($urandom);
        set_baud = 3'd4; parity_mode = 2'd0; stop2 = 1'b0;
        fork
            begin
                accepted = 0;
                dropped = 1'b0;
                for (int i = 0; i < 50 && !dropped; i++) begin
                    bus.s_valid = 1'b1;
                    bus.s_data  = (accepted <= FIFO_DEPTH) ? w[accepted] : 8'hEE;
                    if (bus.s_ready === 1'b1) begin
                        @(posedge clk);
                        accepted++;
                        @(negedge clk);
                    end else begin
                        dropped = 1'b1;
                    end
                end
                bus.s_valid = 1'b0;
                tests++;
                if (accepted != FIFO_DEPTH + 1) begin
                    fails++;
                    $display("[TB] FAIL fifo_accepts: %0d words before s_ready dropped, required %0d", accepted, FIFO_DEPTH + 1);
                end
            end
            begin
                for (int k = 0; k <= FIFO_DEPTH; k++) begin
                    check_frame("fifo", w[k], 3'd4, 2'd0, 1'b0, (k < FIFO_DEPTH), 1'b0, sw);
                end
            end
        join
        check_idle_after("fifo");
    endtask
`endif

    initial begin
        test_reset();
        test_a5();
        test_parity();
        test_back_to_back();
        test_mid_reset();
        test_baud_codes();
        test_random_frames();
`ifdef UART_TX_FIFO_EN
        test_fifo_burst();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
